// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 opcodes, control-word bit map, named control words, T-state enum
package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int CON_W    = 12;

    // Opcodes carried in IR[7:4]
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions inside CON, MSB first
    localparam int CON_CP     = 11;
    localparam int CON_EP     = 10;
    localparam int CON_LM_BAR = 9;
    localparam int CON_CE_BAR = 8;
    localparam int CON_LI_BAR = 7;
    localparam int CON_EI_BAR = 6;
    localparam int CON_LA_BAR = 5;
    localparam int CON_EA     = 4;
    localparam int CON_SU     = 3;
    localparam int CON_EU     = 2;
    localparam int CON_LB_BAR = 1;
    localparam int CON_LO_BAR = 0;

    // Named control words; idle has every active-low strobe high
    localparam logic [11:0] CON_IDLE   = 12'h3E3;
    localparam logic [11:0] CON_T1     = 12'h5E3;  // Ep, Lm
    localparam logic [11:0] CON_T2     = 12'hBE3;  // Cp
    localparam logic [11:0] CON_T3     = 12'h263;  // CE, Li
    localparam logic [11:0] CON_MEM_T4 = 12'h1A3;  // Lm, Ei (LDA/ADD/SUB)
    localparam logic [11:0] CON_LDA_T5 = 12'h2C3;  // CE, La
    localparam logic [11:0] CON_ALU_T5 = 12'h2E1;  // CE, Lb (ADD/SUB)
    localparam logic [11:0] CON_ADD_T6 = 12'h3C7;  // La, Eu
    localparam logic [11:0] CON_SUB_T6 = 12'h3CF;  // La, Su, Eu
    localparam logic [11:0] CON_OUT_T4 = 12'h3F2;  // Ea, Lo

    typedef enum logic [2:0] {
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALT
    } tstate_t;

endpackage

// File: rtl/controller_sequencer_if.sv
// rtl/controller_sequencer_if.sv - opcode in, control word / T-state / halt out
interface controller_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int CON_W    = 12
);
    logic [OPCODE_W-1:0] OPCODE;
    logic [CON_W-1:0]    CON;
    logic [5:0]          T;
    logic                HLT;

    modport master (output OPCODE, input CON, input T, input HLT);
    modport slave  (input OPCODE, output CON, output T, output HLT);
endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// rtl/controller_sequencer_ring_counter.sv - six-bit one-hot T-state ring with hold and reload
module ring_counter (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       hold,
    input  logic       load_t1,
    output logic [5:0] ring
);

    // Rotate one position per edge; hold freezes, load_t1 short-cuts back to T1
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ring <= 6'b000001;
        end else if (!hold) begin
            if (load_t1) begin
                ring <= 6'b000001;
            end else begin
                ring <= {ring[4:0], ring[5]};
            end
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 controller-sequencer; SAP_VARIABLE_MC_EN enables variable machine cycle
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CON_W    = 12
) (
    input  logic                   CLK_BAR,
    input  logic                   CLR_BAR,
    controller_sequencer_if.slave  bus
);

    logic [OPCODE_W-1:0] opcode;
    logic [CON_W-1:0]    con;
    logic [5:0]          ring;
    logic                halt_q;
    logic                halt_d;
    logic                hlt;
    logic                load_t1;
    tstate_t             state;

    assign opcode = bus.OPCODE;

    ring_counter u_ring (
        .clk     (CLK_BAR),
        .clr_n   (CLR_BAR),
        .hold    (halt_q),
        .load_t1 (load_t1),
        .ring    (ring)
    );

    // Halt flag: set on leaving T4 of HLT, cleared only by CLR_BAR
    always_ff @(posedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Map the one-hot ring plus halt flag onto the named state
    always_comb begin
        state = T1;
        unique case (ring)
            6'b000001: state = T1;
            6'b000010: state = T2;
            6'b000100: state = T3;
            6'b001000: state = T4;
            6'b010000: state = T5;
            6'b100000: state = T6;
            default:   state = T1;
        endcase
        if (halt_q) state = HALT;
    end

    // Opcode decode into control word, halt request and early-return
    always_comb begin
        con     = CON_IDLE;
        halt_d  = halt_q;
        hlt     = halt_q;
        load_t1 = 1'b0;
        case (state)
            T1: con = CON_T1;
            T2: con = CON_T2;
            T3: con = CON_T3;
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: con = CON_MEM_T4;
                    OP_OUT: begin
                        con = CON_OUT_T4;
`ifdef SAP_VARIABLE_MC_EN
                        load_t1 = 1'b1;
`endif
                    end
                    OP_HLT: begin
                        hlt    = 1'b1;
                        halt_d = 1'b1;
                    end
                    default: begin
`ifdef SAP_VARIABLE_MC_EN
                        load_t1 = 1'b1;
`endif
                    end
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        con = CON_LDA_T5;
`ifdef SAP_VARIABLE_MC_EN
                        load_t1 = 1'b1;
`endif
                    end
                    OP_ADD, OP_SUB: con = CON_ALU_T5;
                    default: con = CON_IDLE;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD:  con = CON_ADD_T6;
                    OP_SUB:  con = CON_SUB_T6;
                    default: con = CON_IDLE;
                endcase
            end
            HALT: hlt = 1'b1;
            default: con = CON_IDLE;
        endcase
    end

    assign bus.CON = con;
    assign bus.HLT = hlt;
    assign bus.T   = halt_q ? 6'b000000 : ring;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - directed checks of T-state sequencing, CON decode, halt and reset
module tb_controller_sequencer;

    logic CLK_BAR;
    logic CLR_BAR;
    int   vectors;
    int   miscompares;

    controller_sequencer_if #(.OPCODE_W(4), .CON_W(12)) bus ();

    controller_sequencer #(.OPCODE_W(4), .CON_W(12)) dut (
        .CLK_BAR (CLK_BAR),
        .CLR_BAR (CLR_BAR),
        .bus     (bus)
    );

    initial CLK_BAR = 1'b0;
    always #5 CLK_BAR = ~CLK_BAR;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_BAR);
        #1;
    endtask

    // Hand table of CON per T-state and opcode
    function automatic logic [11:0] exp_con(input int t, input logic [3:0] op);
        case (t)
            1: return 12'h5E3;
            2: return 12'hBE3;
            3: return 12'h263;
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) return 12'h1A3;
                if (op == 4'hE) return 12'h3F2;
                return 12'h3E3;
            end
            5: begin
                if (op == 4'h0) return 12'h2C3;
                if (op == 4'h1 || op == 4'h2) return 12'h2E1;
                return 12'h3E3;
            end
            default: begin
                if (op == 4'h1) return 12'h3C7;
                if (op == 4'h2) return 12'h3CF;
                return 12'h3E3;
            end
        endcase
    endfunction

    // Number of T-states an instruction occupies
    function automatic int n_states(input logic [3:0] op);
`ifdef SAP_VARIABLE_MC_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return (op == 4'h0) ? 6 : 6;
`endif
    endfunction

    // Run one instruction starting in T1; optionally scramble OPCODE during fetch
    task automatic run_instr(input logic [3:0] op, input bit scramble);
        int n;
        n = n_states(op);
        for (int t = 1; t <= n; t++) begin
            if (scramble && t <= 3) bus.OPCODE = 4'($urandom_range(0, 15));
            else bus.OPCODE = op;
            #1;
            chk($sformatf("op%0h_T%0d_T", op, t), 32'(bus.T), 32'(6'b1 << (t - 1)));
            chk($sformatf("op%0h_T%0d_CON", op, t), 32'(bus.CON), 32'(exp_con(t, op)));
            chk($sformatf("op%0h_T%0d_HLT", op, t), 32'(bus.HLT), 32'd0);
            step();
        end
        chk($sformatf("op%0h_wrap_T", op), 32'(bus.T), 32'h01);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.OPCODE  = 4'h0;
        CLR_BAR     = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK_BAR);
        #1;
        chk("rst_T", 32'(bus.T), 32'h01);
        chk("rst_CON", 32'(bus.CON), 32'h5E3);
        chk("rst_HLT", 32'(bus.HLT), 32'd0);
        CLR_BAR = 1'b1;

        // Main decode for each defined opcode and some NOPs
        run_instr(4'h0, 1'b0);
        run_instr(4'h2, 1'b0);
        run_instr(4'h1, 1'b0);
        run_instr(4'hE, 1'b0);
        run_instr(4'h7, 1'b1);
        run_instr(4'h3, 1'b0);
        run_instr(4'hD, 1'b1);
        run_instr(4'h0, 1'b1);

        // Halt: fetch, T4 request, then frozen for 10 edges
        bus.OPCODE = 4'hF;
        for (int t = 1; t <= 3; t++) begin
            #1;
            chk($sformatf("hlt_fetch_T%0d_CON", t), 32'(bus.CON), 32'(exp_con(t, 4'hF)));
            chk($sformatf("hlt_fetch_T%0d_HLT", t), 32'(bus.HLT), 32'd0);
            step();
        end
        chk("hlt_T4_T", 32'(bus.T), 32'h08);
        chk("hlt_T4_HLT", 32'(bus.HLT), 32'd1);
        chk("hlt_T4_CON", 32'(bus.CON), 32'h3E3);
        for (int e = 0; e < 11; e++) begin
            step();
            if (e == 3) bus.OPCODE = 4'h1;
            chk($sformatf("halt_e%0d_T", e), 32'(bus.T), 32'h00);
            chk($sformatf("halt_e%0d_CON", e), 32'(bus.CON), 32'h3E3);
            chk($sformatf("halt_e%0d_HLT", e), 32'(bus.HLT), 32'd1);
        end
        #1;
        CLR_BAR = 1'b0;
        #1;
        chk("halt_clr_T", 32'(bus.T), 32'h01);
        chk("halt_clr_CON", 32'(bus.CON), 32'h5E3);
        chk("halt_clr_HLT", 32'(bus.HLT), 32'd0);
        CLR_BAR = 1'b1;
        #1;
        run_instr(4'h2, 1'b0);

        // Asynchronous clear in the middle of LDA T5
        bus.OPCODE = 4'h0;
        repeat (4) step();
        chk("mid_T5_T", 32'(bus.T), 32'h10);
        chk("mid_T5_CON", 32'(bus.CON), 32'h2C3);
        #2;
        CLR_BAR = 1'b0;
        #1;
        chk("async_clr_T", 32'(bus.T), 32'h01);
        chk("async_clr_CON", 32'(bus.CON), 32'h5E3);
        chk("async_clr_HLT", 32'(bus.HLT), 32'd0);
        CLR_BAR = 1'b1;
        #1;
        run_instr(4'h1, 1'b0);
        run_instr(4'hE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
SAP-1 controller-sequencer. It runs the six-state T-cycle (T1..T6) and decodes the instruction-register opcode into the 12-bit control word CON. CON drives the program counter (Cp/Ep), MAR, RAM, IR, accumulator, adder/subtracter, B and output registers. It also raises HLT, which gates the system clock.

Parameters:
- OPCODE_W, 4, width of the opcode field taken from IR[7:4].
- CON_W, 12, control-word width; fixed at 12, and the parameter exists only for port sizing.

Ports:
- CLK_BAR  in  1  inverted system clock. All state updates on the rising edge of CLK_BAR (the falling edge of CLK), so CON is settled before the next CLK rising edge.
- CLR_BAR  in  1  asynchronous, active-low reset.
- OPCODE  in  OPCODE_W  IR upper nibble; valid from T4 onward.
- CON  out  CON_W  control word, bit order MSB..LSB: Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar.
- T  out  6  one-hot T-state. T[0]=T1 ... T[5]=T6. All zero while halted.
- HLT  out  1  halt request, active high.

Behaviour:
- Reset: CLR_BAR=0 asynchronously forces state=T1 and clears the halt flag. Outputs during reset: T=6'b000001, CON=12'h5E3, HLT=0.
- Sequencing: T1->T2->...->T6->T1, one state per CLK_BAR rising edge. Wraps from T6 to T1.
- Both T and CON are decoded combinationally from the state register and OPCODE. No extra latency.
- CON idle value is 12'h3E3 (all active-low bits high, active-high bits low).
- Fetch states (all opcodes):
  - T1: 12'h5E3 (Ep, Lm).
  - T2: 12'hBE3 (Cp).
  - T3: 12'h263 (CE, Li).
- LDA 4'h0: T4 12'h1A3 (Lm, Ei); T5 12'h2C3 (CE, La); T6 12'h3E3.
- ADD 4'h1: T4 12'h1A3; T5 12'h2E1 (CE, Lb); T6 12'h3C7 (La, Eu).
- SUB 4'h2: T4 12'h1A3; T5 12'h2E1; T6 12'h3CF (La, Su, Eu).
- OUT 4'hE: T4 12'h3F2 (Ea, Lo); T5 and T6 12'h3E3.
- HLT 4'hF:
  - In T4, HLT=1 combinationally and CON=12'h3E3.
  - The next edge enters the HALT state: T=0, CON=12'h3E3, HLT=1.
  - HALT holds until CLR_BAR is asserted. Edges in HALT have no effect.
- Undefined opcodes (4'h3..4'hD): NOP. T4..T6 give CON=12'h3E3; sequencing continues.
- OPCODE changes during T1..T3 have no effect on CON.
- Reset mid-cycle, in any state including HALT: immediate return to T1 and HLT=0. No partial-instruction recovery.
- Exactly one CON bit pattern per state. Cp and Ep are never active in the same state.

Optional Feature:
- Macro: SAP_VARIABLE_MC_EN.
- Defined: variable machine cycle. After the last non-NOP state the sequencer returns to T1 instead of idling:
  - LDA: T5->T1.
  - OUT: T4->T1.
  - Undefined opcode: T3->T4->T1. T4 still decodes the opcode and outputs 12'h3E3.
  - ADD and SUB keep all six states.
  - HLT handling is unchanged.
- Undefined: fixed six-state cycle as specified in Behaviour.

Decomposition:
- Package sap1_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - CON bit-index localparams;
  - named CON constants (CON_IDLE=12'h3E3, CON_T1, CON_T2, CON_T3, etc.);
  - the tstate_t enum (T1..T6, HALT).
- Sub-module ring_counter: 6-bit one-hot ring with async active-low clear to 6'b000001, plus hold and load-T1 inputs. The controller owns the opcode decode and the HALT flag.

Test Plan:
- Reset then run with OPCODE=4'h0: T goes 01,02,04,08,10,20,01. CON goes 5E3, BE3, 263, 1A3, 2C3, 3E3. HLT=0 throughout.
- OPCODE=4'h2 over a full cycle: T6 gives CON=12'h3CF. OPCODE=4'h1 over a full cycle: T6 gives CON=12'h3C7 and T5 gives 12'h2E1.
- OPCODE=4'hF: at T4, HLT=1. After the next edge, T=0, CON=3E3 and HLT stays 1 for 10 further edges. Pulse CLR_BAR low: T=01, CON=5E3, HLT=0.
- Assert CLR_BAR asynchronously mid-T5 of an LDA, off the clock edge: T=01 and CON=5E3 immediately, before the next CLK_BAR edge.
- OPCODE=4'h7: T4..T6 CON=3E3 and wrap to T1. Toggling OPCODE during T1..T3 leaves CON at 5E3, BE3, 263.
- With SAP_VARIABLE_MC_EN defined:
  - OUT: T1,T2,T3,T4,T1, 4 edges per instruction.
  - LDA: 5 edges per instruction.
  - ADD: still 6 edges.
  - Expected T sequence is checked against a behavioural model.
